// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM stage: branch/jump redirect, bus load/store with wait timeout, MEM/WB register
module mem_stage_lsu #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  EX_MEM_LS_bit,
    input  logic [1:0]  EX_MEM_Branch,
    input  logic        EX_MEM_MemtoReg,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_Jump,
    input  logic        EX_MEM_Ext_op,
    input  logic        EX_MEM_PctoReg,
    input  logic [31:0] EX_MEM_branch_add_out,
    input  logic        EX_MEM_zero,
    input  logic [31:0] EX_MEM_pc_add_out,
    input  logic [25:0] EX_MEM_instr26,
    input  logic [31:0] EX_MEM_alu_out,
    input  logic [31:0] EX_MEM_regfile_out2,
    input  logic [4:0]  EX_MEM_mux1_out,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        MEM_WB_RegWrite,
    output logic [31:0] MEM_WB_wdata,
    output logic [4:0]  MEM_WB_dst,
    output logic        misalign,
    output logic        bus_err
);
    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, alt_q, alt_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  ls_q, ls_d;
    logic        we_q, we_d, ext_q, ext_d, rw_q, rw_d, sel_load_q, sel_load_d;
    logic [4:0]  dst_q, dst_d;
    logic        wb_rw_q, wb_rw_d, mis_q, mis_d, berr_q, berr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_dst_q, wb_dst_d;

    logic        access, is_half, is_byte, is_word, mis, timeout;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, nonload_wb, lane_shift, load_data;
    logic [15:0] half_v;

    assign access  = EX_MEM_MemtoReg | EX_MEM_MemWrite;
    assign is_half = (EX_MEM_LS_bit == 2'b01);
    assign is_byte = (EX_MEM_LS_bit == 2'b10);
    assign is_word = !is_half && !is_byte;
    assign mis     = (is_half & EX_MEM_alu_out[0]) | (is_word & (EX_MEM_alu_out[1:0] != 2'b00));

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = EX_MEM_regfile_out2;
        if (is_byte) begin
            be_c    = 4'b0001 << EX_MEM_alu_out[1:0];
            wdata_c = {4{EX_MEM_regfile_out2[7:0]}};
        end else if (is_half) begin
            be_c    = EX_MEM_alu_out[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{EX_MEM_regfile_out2[15:0]}};
        end
    end

    assign nonload_wb = EX_MEM_PctoReg ? EX_MEM_pc_add_out : EX_MEM_alu_out;

    // Lane extraction uses the address latched at request time, not the live EX/MEM value.
    assign lane_shift = dbus_rdata >> {addr_q[1:0], 3'b000};
    assign half_v     = addr_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

    always_comb begin
        load_data = dbus_rdata;
        if (ls_q == 2'b10)
            load_data = {{24{ext_q & lane_shift[7]}}, lane_shift[7:0]};
        else if (ls_q == 2'b01)
            load_data = {{16{ext_q & half_v[15]}}, half_v};
    end

    assign timeout = (state_q == BUSY) && !dbus_ack && (cnt_q == CW'(WAIT_LIMIT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        alt_d      = alt_q;
        be_d       = be_q;
        ls_d       = ls_q;
        we_d       = we_q;
        ext_d      = ext_q;
        rw_d       = rw_q;
        sel_load_d = sel_load_q;
        dst_d      = dst_q;
        wb_rw_d    = 1'b0;
        wb_data_d  = wb_data_q;
        wb_dst_d   = wb_dst_q;
        mis_d      = 1'b0;
        berr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (mis) begin
                        mis_d = 1'b1;
                    end else begin
                        addr_d     = EX_MEM_alu_out;
                        wdata_d    = wdata_c;
                        be_d       = be_c;
                        ls_d       = EX_MEM_LS_bit;
                        we_d       = EX_MEM_MemWrite;
                        ext_d      = EX_MEM_Ext_op;
                        rw_d       = EX_MEM_RegWrite;
                        sel_load_d = EX_MEM_MemtoReg & !EX_MEM_PctoReg;
                        alt_d      = nonload_wb;
                        dst_d      = EX_MEM_mux1_out;
                        cnt_d      = '0;
                        state_d    = BUSY;
                    end
                end else begin
                    wb_rw_d   = EX_MEM_RegWrite;
                    wb_data_d = nonload_wb;
                    wb_dst_d  = EX_MEM_mux1_out;
                end
            end
            BUSY: begin
                if (dbus_ack) begin
                    wb_rw_d   = rw_q;
                    wb_data_d = sel_load_q ? load_data : alt_q;
                    wb_dst_d  = dst_q;
                    state_d   = IDLE;
                end else if (timeout) begin
                    berr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            alt_q      <= '0;
            be_q       <= '0;
            ls_q       <= '0;
            we_q       <= 1'b0;
            ext_q      <= 1'b0;
            rw_q       <= 1'b0;
            sel_load_q <= 1'b0;
            dst_q      <= '0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= '0;
            wb_dst_q   <= '0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            alt_q      <= alt_d;
            be_q       <= be_d;
            ls_q       <= ls_d;
            we_q       <= we_d;
            ext_q      <= ext_d;
            rw_q       <= rw_d;
            sel_load_q <= sel_load_d;
            dst_q      <= dst_d;
            wb_rw_q    <= wb_rw_d;
            wb_data_q  <= wb_data_d;
            wb_dst_q   <= wb_dst_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
        end
    end

    assign dbus_req   = (state_q == BUSY);
    assign dbus_we    = we_q;
    assign dbus_addr  = {addr_q[31:2], 2'b00};
    assign dbus_be    = be_q;
    assign dbus_wdata = wdata_q;
    assign stall      = (state_q == IDLE) ? (access & !mis) : (!dbus_ack & !timeout);

    // Redirect is purely combinational so a held jump keeps steering fetch while stalled.
    always_comb begin
        pc_redirect = 1'b0;
        pc_target   = '0;
        if (EX_MEM_Jump) begin
            pc_redirect = 1'b1;
            pc_target   = {EX_MEM_pc_add_out[31:28], EX_MEM_instr26, 2'b00};
        end else if ((EX_MEM_Branch == 2'b01 && EX_MEM_zero) || (EX_MEM_Branch == 2'b10 && !EX_MEM_zero)) begin
            pc_redirect = 1'b1;
            pc_target   = EX_MEM_branch_add_out;
        end
    end

    assign MEM_WB_RegWrite = wb_rw_q;
    assign MEM_WB_wdata    = wb_data_q;
    assign MEM_WB_dst      = wb_dst_q;
    assign misalign        = mis_q;
    assign bus_err         = berr_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu with a transaction-level model
module tb_mem_stage_lsu;
    localparam int WL = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  EX_MEM_LS_bit, EX_MEM_Branch;
    logic        EX_MEM_MemtoReg, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_Jump;
    logic        EX_MEM_Ext_op, EX_MEM_PctoReg, EX_MEM_zero;
    logic [31:0] EX_MEM_branch_add_out, EX_MEM_pc_add_out, EX_MEM_alu_out, EX_MEM_regfile_out2;
    logic [25:0] EX_MEM_instr26;
    logic [4:0]  EX_MEM_mux1_out;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        stall, pc_redirect, MEM_WB_RegWrite, misalign, bus_err;
    logic [31:0] pc_target, MEM_WB_wdata;
    logic [4:0]  MEM_WB_dst;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic        exp_stall, exp_req, exp_we, exp_rw, exp_mis, exp_berr, exp_wbchk;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_wd;
    logic [4:0]  exp_dst;
    logic        nxt_rw, nxt_mis, nxt_berr, nxt_wbchk;
    logic [31:0] nxt_wd;
    logic [4:0]  nxt_dst;
    logic [32:0] redir;

    always #5 clock = ~clock;

    mem_stage_lsu #(.WAIT_LIMIT(WL)) dut (
        .clock(clock), .reset(reset),
        .EX_MEM_LS_bit(EX_MEM_LS_bit), .EX_MEM_Branch(EX_MEM_Branch),
        .EX_MEM_MemtoReg(EX_MEM_MemtoReg), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_Jump(EX_MEM_Jump),
        .EX_MEM_Ext_op(EX_MEM_Ext_op), .EX_MEM_PctoReg(EX_MEM_PctoReg),
        .EX_MEM_branch_add_out(EX_MEM_branch_add_out), .EX_MEM_zero(EX_MEM_zero),
        .EX_MEM_pc_add_out(EX_MEM_pc_add_out), .EX_MEM_instr26(EX_MEM_instr26),
        .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_regfile_out2(EX_MEM_regfile_out2),
        .EX_MEM_mux1_out(EX_MEM_mux1_out),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_wdata(MEM_WB_wdata), .MEM_WB_dst(MEM_WB_dst),
        .misalign(misalign), .bus_err(bus_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic m_mis(input logic [1:0] ls, input logic [31:0] a);
        if (ls == 2'b01) return a[0];
        if (ls == 2'b10) return 1'b0;
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] ls, input logic [31:0] a);
        if (ls == 2'b10) return 4'(1 << a[1:0]);
        if (ls == 2'b01) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] ls, input logic [31:0] d);
        if (ls == 2'b10) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (ls == 2'b01) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] ls, input logic [31:0] a,
                                           input logic [31:0] rd, input logic ext);
        logic [31:0] v;
        if (ls == 2'b10) begin
            v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
            if (ext && v[7]) v = v | 32'hFFFF_FF00;
        end else if (ls == 2'b01) begin
            v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
            if (ext && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [32:0] m_redir(input logic j, input logic [1:0] br, input logic z,
                                            input logic [31:0] pc, input logic [25:0] idx,
                                            input logic [31:0] bt);
        if (j) return {1'b1, pc[31:28], idx, 2'b00};
        if ((br == 2'b01 && z) || (br == 2'b10 && !z)) return {1'b1, bt};
        return 33'd0;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            redir = m_redir(EX_MEM_Jump, EX_MEM_Branch, EX_MEM_zero, EX_MEM_pc_add_out,
                            EX_MEM_instr26, EX_MEM_branch_add_out);
            chk("pc_redirect", 32'(pc_redirect), 32'(redir[32]));
            chk("pc_target", pc_target, redir[31:0]);
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("dbus_req", 32'(dbus_req), 32'(exp_req));
            if (exp_req) begin
                chk("dbus_addr", dbus_addr, exp_addr);
                chk("dbus_be", 32'(dbus_be), 32'(exp_be));
                chk("dbus_we", 32'(dbus_we), 32'(exp_we));
                if (exp_we) chk("dbus_wdata", dbus_wdata, exp_wdata);
            end
            chk("MEM_WB_RegWrite", 32'(MEM_WB_RegWrite), 32'(exp_rw));
            chk("misalign", 32'(misalign), 32'(exp_mis));
            chk("bus_err", 32'(bus_err), 32'(exp_berr));
            if (exp_wbchk) begin
                chk("MEM_WB_wdata", MEM_WB_wdata, exp_wd);
                chk("MEM_WB_dst", 32'(MEM_WB_dst), 32'(exp_dst));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        exp_rw    = nxt_rw;
        exp_mis   = nxt_mis;
        exp_berr  = nxt_berr;
        exp_wbchk = nxt_wbchk;
        exp_wd    = nxt_wd;
        exp_dst   = nxt_dst;
        nxt_rw    = 1'b0;
        nxt_mis   = 1'b0;
        nxt_berr  = 1'b0;
        nxt_wbchk = 1'b0;
        #1;
        dbus_ack = 1'b0;
    endtask

    task automatic set_instr(input logic [1:0] ls, input logic [1:0] br, input logic mtr,
                             input logic mw, input logic rw, input logic j, input logic ext,
                             input logic pcto, input logic [31:0] bt, input logic z,
                             input logic [31:0] pc, input logic [25:0] idx,
                             input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] dst);
        EX_MEM_LS_bit = ls;  EX_MEM_Branch = br;  EX_MEM_MemtoReg = mtr;
        EX_MEM_MemWrite = mw; EX_MEM_RegWrite = rw; EX_MEM_Jump = j;
        EX_MEM_Ext_op = ext; EX_MEM_PctoReg = pcto; EX_MEM_branch_add_out = bt;
        EX_MEM_zero = z; EX_MEM_pc_add_out = pc; EX_MEM_instr26 = idx;
        EX_MEM_alu_out = alu; EX_MEM_regfile_out2 = rs2; EX_MEM_mux1_out = dst;
    endtask

    task automatic nop_op(input logic rw, input logic pcto, input logic [31:0] alu,
                          input logic [31:0] pc, input logic [4:0] dst, input logic [1:0] br,
                          input logic z, input logic j, input logic [31:0] bt, input logic [25:0] idx);
        set_instr(2'b00, br, 1'b0, 1'b0, rw, j, 1'b0, pcto, bt, z, pc, idx, alu, 32'h0, dst);
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        nxt_rw    = rw;
        nxt_wd    = pcto ? pc : alu;
        nxt_dst   = dst;
        nxt_wbchk = 1'b1;
        step();
    endtask

    task automatic mem_op(input logic [1:0] ls, input logic load, input logic ext, input logic pcto,
                          input logic rw, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] pc, input logic [4:0] dst, input int ack_after,
                          input logic [31:0] rdata);
        set_instr(ls, 2'b00, load, !load, rw, 1'b0, ext, pcto, 32'h0, 1'b0, pc, 26'h0, addr, rs2, dst);
        if (m_mis(ls, addr)) begin
            exp_stall = 1'b0;
            exp_req   = 1'b0;
            nxt_mis   = 1'b1;
            step();
            return;
        end
        exp_stall = 1'b1;
        exp_req   = 1'b0;
        step();
        for (int k = 1; k <= WL; k++) begin
            exp_req   = 1'b1;
            exp_addr  = addr & ~32'h3;
            exp_be    = m_be(ls, addr);
            exp_wdata = m_wdata(ls, rs2);
            exp_we    = !load;
            if (k == ack_after) begin
                dbus_ack   = 1'b1;
                dbus_rdata = rdata;
                exp_stall  = 1'b0;
                nxt_rw     = rw;
                nxt_wd     = pcto ? pc : (load ? m_load(ls, addr, rdata, ext) : addr);
                nxt_dst    = dst;
                nxt_wbchk  = 1'b1;
                step();
                break;
            end else if (k == WL) begin
                exp_stall = 1'b0;
                nxt_berr  = 1'b1;
                step();
            end else begin
                exp_stall = 1'b1;
                step();
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        dbus_ack = 1'b0;
        dbus_rdata = 32'h0;
        set_instr(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0, 5'd0);
        nxt_rw = 1'b0; nxt_mis = 1'b0; nxt_berr = 1'b0; nxt_wbchk = 1'b1;
        nxt_wd = 32'h0; nxt_dst = 5'd0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_be = 4'h0;
        exp_addr = 32'h0; exp_wdata = 32'h0;
        step();
        chk_en = 1'b1;
        nxt_wbchk = 1'b1; nxt_wd = 32'h0; nxt_dst = 5'd0;
        step();
        reset = 1'b0;

        chk("pin_lb_sext", m_load(2'b10, 32'h103, 32'h80FF_FF7F, 1'b1), 32'hFFFF_FF80);
        chk("pin_lb_zext", m_load(2'b10, 32'h103, 32'h80FF_FF7F, 1'b0), 32'h0000_0080);
        chk("pin_sh_be", 32'(m_be(2'b01, 32'h102)), 32'hC);
        chk("pin_sh_wdata", m_wdata(2'b01, 32'h1234_ABCD), 32'hABCD_ABCD);
        chk("pin_lw_mis", 32'(m_mis(2'b00, 32'h101)), 32'h1);
        redir = m_redir(1'b1, 2'b01, 1'b1, 32'hA000_0004, 26'h0123456, 32'h3040);
        chk("pin_jump_target", redir[31:0], 32'hA048_D158);

        nop_op(1'b1, 1'b0, 32'h55, 32'h8, 5'd3, 2'b01, 1'b1, 1'b0, 32'h3040, 26'h0);
        nop_op(1'b1, 1'b1, 32'h66, 32'hA000_0004, 5'd31, 2'b01, 1'b1, 1'b1, 32'h3040, 26'h0123456);
        nop_op(1'b0, 1'b0, 32'h77, 32'h10, 5'd4, 2'b10, 1'b0, 1'b0, 32'h1000, 26'h0);
        nop_op(1'b1, 1'b0, 32'h88, 32'h14, 5'd7, 2'b11, 1'b1, 1'b0, 32'h2000, 26'h0);

        mem_op(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 32'h20, 5'd5, 3, 32'hDEAD_BEEF);
        nop_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 26'h0);
        chk("lw_wb_literal_prev", MEM_WB_wdata, 32'h0);
        mem_op(2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 32'h24, 5'd6, 1, 32'h80FF_FF7F);
        mem_op(2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 32'h0, 32'h28, 5'd8, 2, 32'h80FF_FF7F);
        mem_op(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 32'h2C, 5'd9, 1, 32'h8001_1234);
        mem_op(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h102, 32'h1234_ABCD, 32'h30, 5'd0, 1, 32'h0);
        mem_op(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h101, 32'h0000_0077, 32'h34, 5'd0, 2, 32'h0);
        mem_op(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 32'h38, 5'd31, 2, 32'h1111_2222);
        mem_op(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h101, 32'h0, 32'h3C, 5'd10, 1, 32'h0);
        mem_op(2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 32'h0, 32'h40, 5'd11, 1, 32'h0);
        mem_op(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 32'h0, 32'h44, 5'd12, 0, 32'h0);
        nop_op(1'b1, 1'b0, 32'h99, 32'h48, 5'd13, 2'b00, 1'b0, 1'b0, 32'h0, 26'h0);

        set_instr(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4C, 26'h0, 32'h300, 32'h0, 5'd14);
        exp_stall = 1'b1; exp_req = 1'b0;
        step();
        reset = 1'b1;
        exp_stall = 1'b1; exp_req = 1'b1; exp_addr = 32'h300; exp_be = 4'hF; exp_we = 1'b0;
        nxt_wbchk = 1'b1; nxt_wd = 32'h0; nxt_dst = 5'd0;
        step();
        reset = 1'b0;
        set_instr(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0, 5'd0);
        dbus_ack = 1'b1;
        dbus_rdata = 32'hCAFE_F00D;
        exp_stall = 1'b0; exp_req = 1'b0;
        nxt_wbchk = 1'b1; nxt_wd = 32'h0; nxt_dst = 5'd0;
        step();
        nop_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 26'h0);
        nop_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 26'h0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
